// File: rtl/vslc_out_expander_if.sv
// Core-side handshake between the VSLC output image register and the serial
// output-expander driver.
interface vslc_out_expander_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;

  modport master (output start, data, input busy, done);
  modport slave  (input start, data, output busy, done);
endinterface

// File: rtl/vslc_out_expander.sv
// Shifts a parallel output image MSB-first into a 74HC595-style chain, then
// pulses the storage latch. All expander pins and status outputs are registered.
module vslc_out_expander #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vslc_out_expander_if.slave   core,
  output logic                 sclk,
  output logic                 sdo,
  output logic                 rclk
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_e;

  // A DIV of 1 still needs a one-bit divider; it simply wraps every cycle.
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               sdo_q, sdo_d;
  logic               rclk_q, rclk_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every _d gets a default first so no path can leave it unassigned
    // and infer a latch.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    rclk_d    = rclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (core.start && !busy_q) begin
          shift_d   = core.data;
          sdo_d     = core.data[WIDTH-1];
          busy_d    = 1'b1;
          div_d     = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (!div_wrap) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Falling toggle: advance to the next bit, or hand over to the latch.
            if (bit_cnt_q == BIT_LAST) begin
              sdo_d   = 1'b0;
              rclk_d  = 1'b1;
              state_d = LATCH;
            end else begin
              shift_d   = shift_q << 1;
              sdo_d     = shift_q[WIDTH-2];
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end

      LATCH: begin
        if (!div_wrap) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d   = '0;
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      rclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      rclk_q    <= rclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk      = sclk_q;
  assign sdo       = sdo_q;
  assign rclk      = rclk_q;
  assign core.busy = busy_q;
  assign core.done = done_q;

endmodule

// File: tb/tb_vslc_out_expander.sv
// Directed bench for vslc_out_expander: a 16-bit/DIV=4 instance and a
// 2-bit/DIV=1 instance, observed cycle by cycle relative to the accepting edge.
module tb_vslc_out_expander;

  logic clk;
  logic rst_n;
  logic sel;

  int checks;
  int errors;

  vslc_out_expander_if #(.WIDTH(16)) if_a ();
  vslc_out_expander_if #(.WIDTH(2))  if_b ();
  logic sclk_a, sdo_a, rclk_a;
  logic sclk_b, sdo_b, rclk_b;

  vslc_out_expander #(.WIDTH(16), .DIV(4)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (if_a),
    .sclk  (sclk_a),
    .sdo   (sdo_a),
    .rclk  (rclk_a)
  );

  vslc_out_expander #(.WIDTH(2), .DIV(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (if_b),
    .sclk  (sclk_b),
    .sdo   (sdo_b),
    .rclk  (rclk_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic m_sclk, m_sdo, m_rclk, m_busy, m_done;
  assign m_sclk = sel ? sclk_b    : sclk_a;
  assign m_sdo  = sel ? sdo_b     : sdo_a;
  assign m_rclk = sel ? rclk_b    : rclk_a;
  assign m_busy = sel ? if_b.busy : if_a.busy;
  assign m_done = sel ? if_b.done : if_a.done;

  typedef struct {
    int          rises;
    logic [31:0] word;
    int          rise0;
    int          rise1;
    int          rclk_first;
    int          rclk_pulses;
    int          rclk_high;
    int          busy_low;
    int          busy_rerise;
    int          done_first;
    int          done_cnt;
    int          overlap;
  } obs_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Samples the selected DUT #1 after each of the next n_cyc edges; n counts
  // edges after the accepting edge T0.
  task automatic observe(input int n_cyc, output obs_t o);
    logic ps, pr, pb;
    o = '{default: 0};
    ps = 1'b0;
    pr = 1'b0;
    pb = 1'b1;
    for (int n = 1; n <= n_cyc; n++) begin
      @(posedge clk);
      #1;
      if (m_sclk && !ps) begin
        o.rises++;
        o.word = {o.word[30:0], m_sdo};
        if (o.rises == 1) o.rise0 = n;
        if (o.rises == 2) o.rise1 = n;
      end
      if (m_rclk) begin
        o.rclk_high++;
        if (o.rclk_first == 0) o.rclk_first = n;
        if (!pr) o.rclk_pulses++;
      end
      if (!m_busy && o.busy_low == 0) o.busy_low = n;
      if (m_busy && !pb && o.busy_rerise == 0) o.busy_rerise = n;
      if (m_done) begin
        o.done_cnt++;
        if (o.done_first == 0) o.done_first = n;
      end
      if (m_sclk && m_rclk) o.overlap++;
      ps = m_sclk;
      pr = m_rclk;
      pb = m_busy;
    end
  endtask

  // Raises start on DUT A with value v and returns at the accepting edge T0.
  task automatic launch_a(input logic [15:0] v);
    @(posedge clk);
    #2;
    if_a.start = 1'b1;
    if_a.data  = v;
    @(posedge clk);
  endtask

  task automatic check_basic(input string tag, input obs_t o, input logic [15:0] v);
    check({tag, "_rises"},   o.rises, 16);
    check({tag, "_word"},    o.word[15:0], v);
    check({tag, "_rise0"},   o.rise0, 4);
    check({tag, "_rise1"},   o.rise1, 12);
    check({tag, "_rclk_at"}, o.rclk_first, 128);
    check({tag, "_rclk_w"},  o.rclk_high, 4);
    check({tag, "_rclk_n"},  o.rclk_pulses, 1);
    check({tag, "_busy"},    o.busy_low, 132);
    check({tag, "_done_at"}, o.done_first, 132);
    check({tag, "_done_n"},  o.done_cnt, 1);
    check({tag, "_overlap"}, o.overlap, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   bad;
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    rst_n  = 1'b0;
    if_a.start = 1'b0;
    if_a.data  = '0;
    if_b.start = 1'b0;
    if_b.data  = '0;

    // Reset state
    #23;
    check("rst_a", {sclk_a, sdo_a, rclk_a, if_a.busy, if_a.done}, 5'b0);
    check("rst_b", {sclk_b, sdo_b, rclk_b, if_b.busy, if_b.done}, 5'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic transfer
    launch_a(16'hA5C3);
    fork
      observe(140, o);
      begin #2 if_a.start = 1'b0; end
    join
    check_basic("basic", o, 16'hA5C3);

    // Busy rejection: second start at T0+20 and T0+131 must be ignored
    launch_a(16'h00FF);
    fork
      observe(150, o);
      begin
        #2 if_a.start = 1'b0;
        repeat (19) @(posedge clk);
        #2 if_a.start = 1'b1; if_a.data = 16'hFFFF;
        @(posedge clk);
        #2 if_a.start = 1'b0;
        repeat (110) @(posedge clk);
        #2 if_a.start = 1'b1;
        @(posedge clk);
        #2 if_a.start = 1'b0; if_a.data = '0;
      end
    join
    check("rej_rises", o.rises, 16);
    check("rej_word",  o.word[15:0], 16'h00FF);
    check("rej_done",  o.done_cnt, 1);
    check("rej_rerun", o.busy_rerise, 0);

    // Back-to-back with start held high
    launch_a(16'h1234);
    fork
      observe(270, o);
      begin
        #2 if_a.data = 16'h8001;
        repeat (133) @(posedge clk);
        #2 if_a.start = 1'b0;
      end
    join
    check("b2b_rises",  o.rises, 32);
    check("b2b_word",   o.word, 32'h1234_8001);
    check("b2b_busylo", o.busy_low, 132);
    check("b2b_t0",     o.busy_rerise, 133);
    check("b2b_rclk_n", o.rclk_pulses, 2);
    check("b2b_done_n", o.done_cnt, 2);

    // Mid-transfer reset at T0+50
    launch_a(16'hF0F0);
    #2 if_a.start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("mid_busy", if_a.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst", {sclk_a, sdo_a, rclk_a, if_a.busy, if_a.done}, 5'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    observe(200, o);
    check("mid_after", o.rclk_pulses + o.done_cnt + o.rises, 0);
    launch_a(16'h5555);
    fork
      observe(140, o);
      begin #2 if_a.start = 1'b0; end
    join
    check_basic("post", o, 16'h5555);

    // Minimum divider instance
    sel = 1'b1;
    @(posedge clk);
    #2 if_b.start = 1'b1; if_b.data = 2'b10;
    @(posedge clk);
    fork
      observe(10, o);
      begin #2 if_b.start = 1'b0; end
    join
    check("min_rises",  o.rises, 2);
    check("min_word",   o.word[1:0], 2'b10);
    check("min_rise0",  o.rise0, 1);
    check("min_rise1",  o.rise1, 3);
    check("min_rclk",   o.rclk_first, 4);
    check("min_rclk_w", o.rclk_high, 1);
    check("min_busy",   o.busy_low, 5);
    check("min_done",   o.done_first, 5);
    check("min_done_n", o.done_cnt, 1);
    sel = 1'b0;

    // Idle stability
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (sclk_a | sdo_a | rclk_a | if_a.busy | if_a.done |
          sclk_b | sdo_b | rclk_b | if_b.busy | if_b.done) bad++;
    end
    check("idle", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
